// File: rtl/signal_cfg_writer.sv
// Shadow/active signal configuration register file.
// Word writes land in a shadow set; commits copy it to cfg_data.
module signal_cfg_writer #(
  parameter int CFG_WIDTH = 832,
  parameter int WORDS     = 52
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [5:0]           wr_addr,
  input  logic [15:0]          wr_data,
  output logic                 wr_err,
  input  logic                 commit_req,
  input  logic                 sync_en,
  input  logic                 update_tick,
  output logic                 commit_busy,
  output logic                 commit_done,
  input  logic [5:0]           rd_addr,
  input  logic                 rd_sel,
  output logic [15:0]          rd_data,
  output logic [CFG_WIDTH-1:0] cfg_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] APPLY   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] shadow [WORDS];
  logic [15:0] active [WORDS];
  logic        wr_fire;
  logic        wr_ok;
  logic        rd_ok;

  // Reserved words never hold data, so they read 0 everywhere.
  function automatic logic word_ok(input logic [5:0] a);
    logic res;
    res = (a == 6'd23) || (a == 6'd27) ||
          (a == 6'd35) || (a == 6'd39) ||
          (a == 6'd47) || (a == 6'd51);
    return (int'(a) < WORDS) && !res;
  endfunction

  assign wr_ready    = (state == IDLE);
  assign commit_busy = (state != IDLE);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_ok       = word_ok(wr_addr);
  assign rd_ok       = word_ok(rd_addr);

  for (genvar k = 0; k < WORDS; k++) begin : g_pack
    assign cfg_data[16*k +: 16] = active[k];
  end

  // Commit sequencer; sync_en only matters when leaving IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (commit_req) begin
          state_nx = sync_en ? PENDING : APPLY;
        end
      end
      PENDING: begin
        if (update_tick) begin
          state_nx = APPLY;
        end
      end
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and the done/error pulses.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      state       <= state_nx;
      commit_done <= (state == APPLY);
      wr_err      <= wr_fire && !wr_ok;
    end
  end

  // Shadow set takes accepted writes to valid words only.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WORDS; k++) begin
        shadow[k] <= '0;
      end
    end else if (wr_fire && wr_ok) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Active set copies the whole shadow on the APPLY exit edge.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WORDS; k++) begin
        active[k] <= '0;
      end
    end else if (state == APPLY) begin
      for (int k = 0; k < WORDS; k++) begin
        active[k] <= shadow[k];
      end
    end
  end

  // Registered readback of either set.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (!rd_ok) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel ? active[rd_addr] : shadow[rd_addr];
    end
  end

endmodule

// File: tb/tb_signal_cfg_writer.sv
// Bench for signal_cfg_writer: vector table, corner sequences,
// and random traffic against a word-array reference model.
module tb_signal_cfg_writer;

  localparam int W = 832;
  localparam int N = 52;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [5:0]    wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_err;
  logic          commit_req = 1'b0;
  logic          sync_en = 1'b0;
  logic          update_tick = 1'b0;
  logic          commit_busy;
  logic          commit_done;
  logic [5:0]    rd_addr = '0;
  logic          rd_sel = 1'b0;
  logic [15:0]   rd_data;
  logic [W-1:0]  cfg_data;

  signal_cfg_writer #(.CFG_WIDTH(W), .WORDS(N)) dut (
    .aclk(aclk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .commit_req(commit_req), .sync_en(sync_en),
    .update_tick(update_tick), .commit_busy(commit_busy),
    .commit_done(commit_done), .rd_addr(rd_addr),
    .rd_sel(rd_sel), .rd_data(rd_data), .cfg_data(cfg_data)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_sh [N];
  logic [15:0] m_ac [N];
  bit          m_wait;
  bit          m_copy;
  bit          m_done;
  bit          m_err;
  logic [15:0] m_rd;

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
    bit          err;
  } wvec_t;

  wvec_t tv [8];

  function automatic bit ok_addr(int a);
    if (a >= N) return 0;
    if (a == 23 || a == 27 || a == 35) return 0;
    if (a == 39 || a == 47 || a == 51) return 0;
    return 1;
  endfunction

  function automatic logic [W-1:0] m_cfg();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[16*k +: 16] = m_ac[k];
    return r;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < N; k++) begin
      m_sh[k] = '0;
      m_ac[k] = '0;
    end
    m_wait = 0;
    m_copy = 0;
    m_done = 0;
    m_err  = 0;
    m_rd   = '0;
  endtask

  // One clock edge of the reference model, from current inputs.
  task automatic m_edge();
    bit          idle;
    bit          go;
    logic [15:0] rd_n;
    idle = !(m_wait || m_copy);
    go   = idle && wr_valid;
    if (!ok_addr(int'(rd_addr))) rd_n = '0;
    else if (rd_sel) rd_n = m_ac[rd_addr];
    else rd_n = m_sh[rd_addr];
    m_done = m_copy;
    m_err  = go && !ok_addr(int'(wr_addr));
    if (m_copy) begin
      for (int k = 0; k < N; k++) m_ac[k] = m_sh[k];
    end
    if (go && ok_addr(int'(wr_addr))) m_sh[wr_addr] = wr_data;
    if (m_copy) begin
      m_copy = 0;
    end else if (m_wait) begin
      if (update_tick) begin
        m_wait = 0;
        m_copy = 1;
      end
    end else if (commit_req) begin
      if (sync_en) m_wait = 1;
      else m_copy = 1;
    end
    m_rd = rd_n;
  endtask

  task automatic check_all();
    bit busy;
    busy = m_wait || m_copy;
    chk("wr_ready", wr_ready, !busy);
    chk("commit_busy", commit_busy, busy);
    chk("commit_done", commit_done, m_done);
    chk("wr_err", wr_err, m_err);
    chk("rd_data", rd_data, m_rd);
    chk("cfg_data", cfg_data, m_cfg());
  endtask

  task automatic cycle();
    m_edge();
    @(posedge aclk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    wr_valid    = 0;
    commit_req  = 0;
    update_tick = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    m_clear();
    #1;
    check_all();
    @(posedge aclk);
    #1;
    check_all();
    reset = 0;
  endtask

  int dones;

  initial begin
    tv[0] = '{6'd0,  16'h1234, 0};
    tv[1] = '{6'd3,  16'hABCD, 0};
    tv[2] = '{6'd23, 16'hFFFF, 1};
    tv[3] = '{6'd60, 16'h0001, 1};
    tv[4] = '{6'd51, 16'h7777, 1};
    tv[5] = '{6'd50, 16'hBEEF, 0};
    tv[6] = '{6'd52, 16'h1111, 1};
    tv[7] = '{6'd22, 16'h2222, 0};

    m_clear();
    #1;
    check_all();
    do_reset();

    // Vector table of single writes.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1;
      wr_addr  = tv[i].a;
      wr_data  = tv[i].d;
      cycle();
      wr_valid = 0;
      chk("wr_err_tbl", wr_err, tv[i].err);
    end
    rd_addr = 6'd23;
    rd_sel  = 0;
    cycle();
    cycle();
    chk("rd_w23", rd_data, 16'h0000);

    // Immediate commit: two edges to cfg_data.
    sync_en    = 0;
    commit_req = 1;
    cycle();
    commit_req = 0;
    chk("imm_early", commit_done, 1'b0);
    chk("imm_cfg_early", cfg_data[15:0], 16'h0000);
    cycle();
    chk("imm_w0", cfg_data[15:0], 16'h1234);
    chk("imm_w3", cfg_data[63:48], 16'hABCD);
    chk("imm_w23", cfg_data[383:368], 16'h0000);
    chk("imm_done", commit_done, 1'b1);
    cycle();
    chk("imm_done_off", commit_done, 1'b0);

    // Synchronised commit held for 100 cycles.
    wr_valid = 1;
    wr_addr  = 6'd1;
    wr_data  = 16'h4444;
    cycle();
    wr_valid   = 0;
    sync_en    = 1;
    commit_req = 1;
    update_tick = 1;
    cycle();
    commit_req  = 0;
    update_tick = 0;
    sync_en     = 0;
    for (int i = 0; i < 100; i++) cycle();
    chk("pend_busy", commit_busy, 1'b1);
    chk("pend_ready", wr_ready, 1'b0);
    chk("pend_cfg", cfg_data[31:16], 16'h0000);
    update_tick = 1;
    cycle();
    update_tick = 0;
    chk("tick_done_early", commit_done, 1'b0);
    cycle();
    chk("tick_cfg", cfg_data[31:16], 16'h4444);
    chk("tick_done", commit_done, 1'b1);
    cycle();

    // Write with commit in the same cycle, then a busy request.
    sync_en    = 0;
    wr_valid   = 1;
    wr_addr    = 6'd5;
    wr_data    = 16'h00FF;
    commit_req = 1;
    cycle();
    wr_valid = 0;
    dones    = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      commit_req = 0;
      if (commit_done) dones++;
    end
    chk("same_cyc_w5", cfg_data[95:80], 16'h00FF);
    chk("one_done", dones, 1);

    // Shadow vs active readback.
    wr_valid = 1;
    wr_addr  = 6'd2;
    wr_data  = 16'h5555;
    cycle();
    wr_valid = 0;
    rd_addr  = 6'd2;
    rd_sel   = 0;
    cycle();
    chk("rd_shadow", rd_data, 16'h5555);
    rd_sel = 1;
    cycle();
    chk("rd_active", rd_data, 16'h0000);
    rd_addr = 6'd0;
    cycle();
    chk("rd_active_w0", rd_data, 16'h1234);

    // Reset while pending aborts the commit.
    sync_en    = 1;
    commit_req = 1;
    cycle();
    commit_req = 0;
    cycle();
    chk("pre_rst_busy", commit_busy, 1'b1);
    do_reset();
    chk("rst_cfg", cfg_data, '0);
    chk("rst_busy", commit_busy, 1'b0);
    update_tick = 1;
    cycle();
    update_tick = 0;
    cycle();
    chk("rst_no_done", commit_done, 1'b0);
    chk("rst_cfg_kept", cfg_data, '0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_addr     = 6'($urandom_range(0, 63));
      wr_data     = 16'($urandom);
      commit_req  = ($urandom_range(0, 7) == 0);
      sync_en     = ($urandom_range(0, 1) == 1);
      update_tick = ($urandom_range(0, 5) == 0);
      rd_addr     = 6'($urandom_range(0, 63));
      rd_sel      = ($urandom_range(0, 1) == 1);
      cycle();
    end
    quiet();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signal_cfg_writer.md
SIGNAL_CFG_WRITER -- requirements
Module: signal_cfg_writer

Interface
REQ-001 SHALL have parameter CFG_WIDTH, default 832, width of the packed signal configuration bus.
REQ-002 SHALL have parameter WORDS, default 52, number of 16-bit configuration words (CFG_WIDTH/16).
REQ-003 SHALL have port aclk input 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port wr_valid input 1: word write request.
REQ-006 SHALL have port wr_ready output 1: write can be accepted.
REQ-007 SHALL have port wr_addr input 6: word index; word k maps to bits [16k+15:16k].
REQ-008 SHALL have port wr_data input 16: word write data.
REQ-009 SHALL have port wr_err output 1: one-cycle pulse on an accepted write to an invalid word.
REQ-010 SHALL have port commit_req input 1: request to copy the shadow set to the active set.
REQ-011 SHALL have port sync_en input 1: 1 = commit waits for update_tick; 0 = commit is immediate.
REQ-012 SHALL have port update_tick input 1: waveform period boundary strobe.
REQ-013 SHALL have port commit_busy output 1: high in any state other than IDLE.
REQ-014 SHALL have port commit_done output 1: one-cycle pulse in the cycle cfg_data first shows new contents.
REQ-015 SHALL have port rd_addr input 6: readback word index.
REQ-016 SHALL have port rd_sel input 1: 0 = read the shadow set, 1 = read the active set.
REQ-017 SHALL have port rd_data output 16: readback word.
REQ-018 SHALL have port cfg_data output CFG_WIDTH: active packed configuration, registered.

Function
REQ-019 Write acceptance SHALL occur when wr_valid and wr_ready are both high; wr_ready SHALL equal (state==IDLE).
REQ-020 An accepted valid write SHALL update the shadow word at the next edge.
REQ-021 Reserved words 23, 27, 35, 39, 47 and 51 and addresses >= WORDS SHALL be invalid.
REQ-022 An invalid write SHALL leave the shadow unchanged and SHALL assert wr_err on the next cycle for one cycle.
REQ-023 Reserved bit ranges SHALL always read 0 in both the shadow and cfg_data.
REQ-024 The FSM states SHALL be IDLE, PENDING and APPLY.
REQ-025 IDLE with commit_req and sync_en=1 SHALL go to PENDING.
REQ-026 IDLE with commit_req and sync_en=0 SHALL go to APPLY.
REQ-027 PENDING SHALL go to APPLY in a cycle where update_tick=1; update_tick is ignored in the cycle commit_req is accepted.
REQ-028 APPLY SHALL load cfg_data from the shadow at its exiting edge, set commit_done=1 registered with it, and go to IDLE.
REQ-029 commit_req while commit_busy is high SHALL be ignored; it SHALL NOT be queued.
REQ-030 A write and commit_req accepted in the same IDLE cycle SHALL include that write in the commit.
REQ-031 Immediate-commit latency SHALL be: commit_req at edge N, cfg_data updated and commit_done high after edge N+2.
REQ-032 A change of sync_en while in PENDING SHALL NOT affect the pending commit.
REQ-033 rd_data SHALL be registered with one-cycle latency from rd_addr/rd_sel; invalid addresses SHALL return 0.
REQ-034 cfg_data SHALL change only at the APPLY exit edge.

Reset
REQ-035 On reset assertion, asynchronously: shadow=0, cfg_data=0, state=IDLE, wr_err=0, commit_done=0, rd_data=0.
REQ-036 In reset, wr_ready SHALL be 1 and commit_busy SHALL be 0.
REQ-037 Reset during PENDING or APPLY SHALL abort the commit; cfg_data SHALL stay 0 and no commit_done SHALL be issued.

Verification
REQ-038 Write word 0 = 0x1234, word 3 = 0xABCD, sync_en=0, commit -> two cycles later cfg_data[15:0]=0x1234, cfg_data[63:48]=0xABCD, one commit_done pulse.
REQ-039 Write word 23 = 0xFFFF and word 60 = 0x0001 -> two wr_err pulses; shadow readback of word 23 = 0; cfg_data[383:368]=0 after commit.
REQ-040 sync_en=1, commit, hold update_tick low 100 cycles -> cfg_data unchanged, wr_ready=0, commit_busy=1; pulse tick -> update and commit_done one cycle later.
REQ-041 Write word 5 = 0x00FF with commit_req in the same cycle (sync_en=0) -> cfg_data[95:80]=0x00FF after commit; a second commit_req while busy -> exactly one commit_done.
REQ-042 Assert reset while in PENDING -> cfg_data=0, state IDLE, no commit_done; a subsequent update_tick -> no change.
REQ-043 After commit, write word 2 = 0x5555 -> readback rd_sel=0 gives 0x5555, rd_sel=1 gives the old value, each one cycle after the address is applied.
